// File: rtl/mips_regfile_pkg.sv
// Shared defaults and constants for the MIPS-style register file.
// Imported by the top level; the cell is kept generic.
package mips_regfile_pkg;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_DEPTH  = 32;
   localparam int unsigned DEF_NUM_RD = 2;
   localparam int unsigned ZERO_IDX   = 0;
   localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/regfile_cell.sv
// One WIDTH-bit register with synchronous active-high clear and load enable.
module regfile_cell #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mips_regfile.sv
// Multi-read-port register file with optional hardwired zero register,
// same-cycle write forwarding and a saturating committed-write counter.
module mips_regfile
   import mips_regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [NUM_RD*AW-1:0]    raddr,
   output logic [NUM_RD*WIDTH-1:0] rdata,
   output logic [CNT_W-1:0]        wr_count
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             waddr_zero;
   logic             commit;

   assign waddr_zero = ZERO_REG && (waddr == AW'(ZERO_IDX));
   // A write commits only when it survives both reset and zero-register discard.
   assign commit     = we && !Reset && !waddr_zero;

   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      if (ZERO_REG && (i == ZERO_IDX)) begin : g_zero
         assign regs[i] = '0;
      end else begin : g_cell
         regfile_cell #(
            .WIDTH (WIDTH)
         ) u_cell (
            .Clk   (Clk),
            .Reset (Reset),
            .en    (commit && (waddr == AW'(i))),
            .d     (wdata),
            .q     (regs[i])
         );
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_count <= '0;
      end else if (commit && (wr_count != {CNT_W{1'b1}})) begin
         wr_count <= wr_count + 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] rd;

      assign addr = raddr[p*AW +: AW];

      // Zero-register override is applied last so forwarding can never leak into r0.
      always_comb begin
         rd = regs[addr];
         if (BYPASS && commit && (waddr == addr)) begin
            rd = wdata;
         end
         if (ZERO_REG && (addr == AW'(ZERO_IDX))) begin
            rd = '0;
         end
      end

      assign rdata[p*WIDTH +: WIDTH] = rd;
   end

endmodule

// File: tb/tb_mips_regfile.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share stimulus;
// expectations are queued by the driver and checked by a negedge monitor.
module tb_mips_regfile;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;

   logic          Clk;
   logic          Reset;
   logic          we;
   logic [AW-1:0] waddr;
   logic [W-1:0]  wdata;
   logic [2*AW-1:0] raddr;
   logic [2*W-1:0]  rdata_b;
   logic [2*W-1:0]  rdata_n;
   logic [15:0]     cnt_b;
   logic [15:0]     cnt_n;

   mips_regfile #(.BYPASS(1'b1)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr),
      .rdata    (rdata_b),
      .wr_count (cnt_b)
   );

   mips_regfile #(.BYPASS(1'b0)) dut_nb (
      .Clk      (Clk),
      .Reset    (Reset),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr),
      .rdata    (rdata_n),
      .wr_count (cnt_n)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // sel: 0/1 bypass rdata port, 2 bypass wr_count, 3/4 no-bypass rdata port, 5 no-bypass wr_count
   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;

   task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
      item_t it;
      it.name = name;
      it.sel  = sel;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   task automatic expect_rd(input string name, input int port, input logic [31:0] exp_b,
                            input logic [31:0] exp_n);
      expect_val(name, port, exp_b);
      expect_val(name, port + 3, exp_n);
   endtask

   task automatic expect_cnt(input string name, input logic [15:0] exp);
      expect_val(name, 2, {16'h0, exp});
      expect_val(name, 5, {16'h0, exp});
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      while (sb.size() > 0) begin
         item_t       it;
         logic [31:0] act;
         it = sb.pop_front();
         case (it.sel)
            0:       act = rdata_b[31:0];
            1:       act = rdata_b[63:32];
            2:       act = {16'h0, cnt_b};
            3:       act = rdata_n[31:0];
            4:       act = rdata_n[63:32];
            default: act = {16'h0, cnt_n};
         endcase
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s (sel %0d): got %h, expected %h", it.name, it.sel, act, it.exp);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1;
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      raddr = '0;
      step();
      step();
      Reset = 1'b0;

      // Post-reset sweep of every address on both ports
      for (int a = 0; a < 32; a++) begin
         raddr = {AW'(31 - a), AW'(a)};
         expect_rd("reset_rd0", 0, 32'h0, 32'h0);
         expect_rd("reset_rd1", 1, 32'h0, 32'h0);
         if (a == 0) expect_cnt("reset_cnt", 16'd0);
         step();
      end

      // Plain write then read
      we = 1'b1; waddr = 5'd5; wdata = 32'hDCFFFFFF; raddr = '0;
      step();
      we = 1'b0; raddr = {5'd0, 5'd5};
      expect_rd("wr5_rd", 0, 32'hDCFFFFFF, 32'hDCFFFFFF);
      expect_cnt("wr5_cnt", 16'd1);
      step();

      // Write to r0 is discarded, even for the forwarded read
      we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr = {5'd0, 5'd5};
      expect_rd("r0_fwd", 1, 32'h0, 32'h0);
      step();
      we = 1'b0;
      expect_rd("r0_rd", 1, 32'h0, 32'h0);
      expect_cnt("r0_cnt", 16'd1);
      step();

      // Same-cycle forwarding on both ports; the non-bypass copy shows the old value
      we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd7};
      expect_rd("byp_rd1", 1, 32'hA5A5A5A5, 32'h0);
      expect_rd("byp_rd0", 0, 32'hA5A5A5A5, 32'h0);
      step();
      we = 1'b0;
      expect_rd("byp_after1", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
      expect_rd("byp_after0", 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
      expect_cnt("byp_cnt", 16'd2);
      step();

      // Reset wins over a simultaneous write
      we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
      step();
      raddr = {5'd10, 5'd9};
      expect_rd("r9_rd", 0, 32'h11111111, 32'h11111111);
      expect_cnt("r9_cnt", 16'd3);
      Reset = 1'b1; waddr = 5'd10; wdata = 32'h22222222;
      step();
      Reset = 1'b0; we = 1'b0;
      expect_rd("rst_r9", 0, 32'h0, 32'h0);
      expect_rd("rst_r10", 1, 32'h0, 32'h0);
      expect_cnt("rst_cnt", 16'd0);
      step();

      // Saturating write counter
      we = 1'b1; raddr = '0;
      for (int i = 0; i < 65534; i++) begin
         waddr = AW'((i % 31) + 1);
         wdata = i;
         step();
      end
      expect_cnt("sat_fffe", 16'hFFFE);
      step();
      expect_cnt("sat_ffff", 16'hFFFF);
      for (int i = 0; i < 5; i++) step();
      expect_cnt("sat_hold", 16'hFFFF);
      we = 1'b0;
      step();
      expect_cnt("sat_idle", 16'hFFFF);

      @(negedge Clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
